// File: rtl/of_stream_pkg.sv
// of_stream_pkg: shared types and constants for the frame stream source.
package of_stream_pkg;
  typedef enum logic [1:0] {IDLE, READ, BLANK, DRAIN} state_t;
  localparam int RD_LATENCY = 1;
  localparam int PIPE_DEPTH = 2;
  function automatic int clog2_1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sideband_delay.sv
// sideband_delay: fixed-depth register pipe that keeps per-pixel tags aligned with frame-store read data.
module sideband_delay #(
  parameter int W = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] pipe [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/frame_stream_source.sv
// frame_stream_source: raster-order pixel source reading one frame from a synchronous frame store per start.
module frame_stream_source
  import of_stream_pkg::*;
#(
  parameter int WIDTH = 320,
  parameter int HEIGHT = 240,
  parameter int DATA_WIDTH = 12,
  parameter int H_BLANK = 0,
  localparam int AW = clog2_1(WIDTH * HEIGHT),
  localparam int XW = clog2_1(WIDTH),
  localparam int YW = clog2_1(HEIGHT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         pause,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  frame_count,
  output logic                         mem_rd_en,
  output logic [AW-1:0]                mem_rd_addr,
  input  logic signed [DATA_WIDTH-1:0] mem_rd_data,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         data_valid,
  output logic [XW-1:0]                out_x,
  output logic [YW-1:0]                out_y,
  output logic                         sof,
  output logic                         eol
);
  localparam int BW = clog2_1(H_BLANK + 1);
  localparam int SBW = XW + YW + 3;
  state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [BW-1:0] bcnt;
  logic x_end, y_end, rd_q, last_q;
  logic [SBW-1:0] sb_q;
  assign x_end = x == XW'(WIDTH - 1);
  assign y_end = y == YW'(HEIGHT - 1);
  assign mem_rd_en = state == READ && !pause;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      x <= '0;
      y <= '0;
      mem_rd_addr <= '0;
      bcnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= READ;
          busy <= 1'b1;
          x <= '0;
          y <= '0;
          mem_rd_addr <= '0;
        end
        READ: if (!pause) begin
          mem_rd_addr <= mem_rd_addr + 1'b1;
          x <= x_end ? '0 : x + 1'b1;
          if (x_end) begin
            y <= y_end ? '0 : y + 1'b1;
            state <= y_end ? DRAIN : (H_BLANK > 0 ? BLANK : READ);
            bcnt <= '0;
          end
        end
        BLANK: if (!pause) begin
          bcnt <= bcnt + 1'b1;
          if (32'(bcnt) == H_BLANK - 1) state <= READ;
        end
        DRAIN: if (done) begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  // done and frame_count are timed off the final read so they land with the last pixel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q <= 1'b0;
      last_q <= 1'b0;
      done <= 1'b0;
      frame_count <= '0;
      data_out <= '0;
    end else begin
      rd_q <= mem_rd_en;
      last_q <= mem_rd_en && x_end && y_end;
      done <= last_q;
      frame_count <= frame_count + 16'(last_q);
      if (rd_q) data_out <= mem_rd_data;
    end
  sideband_delay #(.W(SBW), .DEPTH(PIPE_DEPTH)) u_sideband (
    .clk(clk),
    .rst_n(rst_n),
    .d({mem_rd_en, x, y, mem_rd_en && x == '0 && y == '0, mem_rd_en && x_end}),
    .q(sb_q)
  );
  assign {data_valid, out_x, out_y, sof, eol} = sb_q;
endmodule

// File: tb/tb_frame_stream_source.sv
// tb_frame_stream_source: randomized frames with pause/restart/reset checked against a raster-order model.
module tb_frame_stream_source;
  localparam int W = 4;
  localparam int H = 3;
  localparam int HB = 2;
  localparam int DW = 12;
  localparam int N = W * H;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic busy, done, mem_rd_en, data_valid, sof, eol;
  logic [15:0] frame_count;
  logic [3:0] mem_rd_addr;
  logic signed [DW-1:0] mem_rd_data = '0;
  logic signed [DW-1:0] data_out;
  logic [1:0] out_x, out_y;
  logic signed [DW-1:0] mem [N];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int exp_rd = 0;
  int exp_out = 0;
  int frames = 0;
  int rdq [$];
  frame_stream_source #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .H_BLANK(HB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .busy(busy), .done(done),
    .frame_count(frame_count), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .data_out(data_out), .data_valid(data_valid),
    .out_x(out_x), .out_y(out_y), .sof(sof), .eol(eol)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // reference model: reads and pixels both walk the frame linearly, each pixel exactly 2 cycles after its read
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rd = 0;
      exp_out = 0;
      frames = 0;
      rdq.delete();
    end else begin
      if (pause) check("rd_while_pause", mem_rd_en, 0);
      if (mem_rd_en) begin
        check("rd_addr", mem_rd_addr, exp_rd);
        rdq.push_back(cyc);
        exp_rd = (exp_rd + 1) % N;
      end
      if (data_valid) begin
        if (rdq.size() == 0) check("valid_without_read", 0, 1);
        else check("latency", cyc - rdq.pop_front(), 2);
        check("data", data_out, mem[exp_out]);
        check("x", out_x, exp_out % W);
        check("y", out_y, exp_out / W);
        check("sof", sof, exp_out == 0);
        check("eol", eol, exp_out % W == W - 1);
        check("done", done, exp_out == N - 1);
        if (done) begin
          check("frame_count", frame_count, frames + 1);
          frames++;
        end
        exp_out = (exp_out + 1) % N;
      end else check("done_without_valid", done, 0);
    end
  end
  task automatic run_frame(input int mode, input bit restart);
    int t0, c, vi, dc, dc_exp;
    bit got;
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    dc_exp = 2 + N + (H - 1) * HB + (mode == 2 ? 4 : 0);
    vi = 0;
    got = 0;
    dc = -1;
    @(posedge clk);
    #1;
    start = 1'b1;
    pause = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      c = cyc - t0;
      if (c == 1) check("busy_set", busy, 1);
      if (data_valid) begin
        if (mode != 1) check("valid_cycle", c, 3 + vi + (vi / W) * HB + ((mode == 2 && vi >= 4) ? 4 : 0));
        vi++;
      end
      if (mode == 2 && (c == 5 || c == 6)) check("trailing_valid", data_valid, 1);
      if (mode == 2 && c >= 7 && c <= 10) check("pause_gap", data_valid, 0);
      if (done) begin
        got = 1;
        dc = c;
      end else begin
        @(posedge clk);
        #1;
        c = cyc - t0;
        pause = mode == 1 ? ($urandom_range(3) == 0) : (mode == 2 && c >= 5 && c <= 8);
        start = restart && (c == dc_exp || (c > 1 && $urandom_range(4) == 0));
      end
    end
    check("done_seen", got, 1);
    check("pixels", vi, N);
    if (mode != 1) check("done_cycle", dc, dc_exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    pause = 1'b0;
    @(negedge clk);
    check("busy_drop", busy, 0);
    repeat (6) @(negedge clk);
    check("stays_idle", busy | data_valid, 0);
  endtask
  task automatic reset_abort();
    int k;
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (k < 50 && !(data_valid && out_x == 2'd2 && out_y == 2'd1)) begin
      @(negedge clk);
      k++;
    end
    check("reach_pixel6", k < 50, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_valid", data_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rd_en", mem_rd_en, 0);
    check("abort_frame_count", frame_count, 0);
    check("abort_data", data_out, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask
  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", data_valid, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_sof_eol", {sof, eol}, 0);
    check("rst_xy", {out_x, out_y}, 0);
    check("rst_data", data_out, 0);
    #2 rst_n = 1'b1;
    reset_abort();
    run_frame(0, 0);
    run_frame(2, 0);
    run_frame(0, 1);
    for (int i = 0; i < 3; i++) run_frame(1, 0);
    run_frame(0, 1);
    check("total_frames", frame_count, 7);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
